// File: rtl/pipe_skid_reg.sv
// Valid/ready pipeline register with a two-entry skid buffer, synchronous flush
// to NOP, and a saturating stall counter for performance debug.
module pipe_skid_reg #(
  parameter int unsigned    PC_W     = 32,
  parameter int unsigned    INSTR_W  = 32,
  parameter int unsigned    EXC_W    = 5,
  parameter int unsigned    CNT_W    = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PC_W-1:0]    in_pc,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [EXC_W-1:0]   in_exc,
  input  logic               in_bd,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PC_W-1:0]    out_pc,
  output logic [INSTR_W-1:0] out_instr,
  output logic [EXC_W-1:0]   out_exc,
  output logic               out_bd,
  output logic [CNT_W-1:0]   stall_cnt
);

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
    logic [EXC_W-1:0]   exc;
    logic               bd;
  } entry_t;

  typedef enum logic [1:0] {EMPTY, BUSY, FULL} state_t;

  localparam entry_t           CLEAR_ENTRY = {RESET_PC, INSTR_W'(0), EXC_W'(0), 1'b0};
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  state_t state;
  entry_t main_q;
  entry_t skid_q;
  entry_t in_entry;
  logic   in_xfer;
  logic   out_xfer;

  // Handshake flags decode only the state register, so out_ready never reaches in_ready.
  assign in_ready  = (state != FULL);
  assign out_valid = (state != EMPTY);
  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = out_valid & out_ready;
  assign in_entry  = {in_pc, in_instr, in_exc, in_bd};

  assign out_pc    = main_q.pc;
  assign out_instr = main_q.instr;
  assign out_exc   = main_q.exc;
  assign out_bd    = main_q.bd;

  // State and storage; main instr is zeroed on draining so an idle output shows a NOP.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      state  <= EMPTY;
      main_q <= CLEAR_ENTRY;
      skid_q <= CLEAR_ENTRY;
    end else begin
      case (state)
        EMPTY: begin
          if (in_xfer) begin
            state  <= BUSY;
            main_q <= in_entry;
          end
        end
        BUSY: begin
          if (in_xfer && out_xfer) begin
            main_q <= in_entry;
          end else if (in_xfer) begin
            state  <= FULL;
            skid_q <= in_entry;
          end else if (out_xfer) begin
            state        <= EMPTY;
            main_q.instr <= '0;
          end
        end
        FULL: begin
          if (out_xfer) begin
            state  <= BUSY;
            main_q <= skid_q;
          end
        end
        default: begin
          state  <= EMPTY;
          main_q <= CLEAR_ENTRY;
          skid_q <= CLEAR_ENTRY;
        end
      endcase
    end
  end

  // Stall counter survives flush; only reset clears it.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != CNT_MAX)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: directed scenarios followed by random traffic, all
// checked against a FIFO-queue reference model of the pipeline register.
module tb_pipe_skid_reg;

  localparam int unsigned CNT_W   = 4;
  localparam int          CNT_SAT = (1 << CNT_W) - 1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_pc = '0;
  logic [31:0] in_instr = '0;
  logic [4:0]  in_exc = '0;
  logic        in_bd = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic [4:0]  out_exc;
  logic        out_bd;
  logic [CNT_W-1:0] stall_cnt;

  pipe_skid_reg #(
    .PC_W(32), .INSTR_W(32), .EXC_W(5), .CNT_W(CNT_W), .RESET_PC(32'h0)
  ) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_instr(in_instr), .in_exc(in_exc), .in_bd(in_bd),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_instr(out_instr), .out_exc(out_exc), .out_bd(out_bd),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [4:0]  exc;
    logic        bd;
  } ent_t;

  // Reference model: held entries in arrival order, stall count, and whether the
  // output still shows the reset/flush image (no entry has arrived since).
  ent_t q[$];
  int   m_cnt = 0;
  bit   m_cleared = 1'b1;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
    chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
    if (q.size() > 0) begin
      chk("out_pc", 64'(out_pc), 64'(q[0].pc));
      chk("out_instr", 64'(out_instr), 64'(q[0].instr));
      chk("out_exc", 64'(out_exc), 64'(q[0].exc));
      chk("out_bd", 64'(out_bd), 64'(q[0].bd));
    end else begin
      chk("out_instr_nop", 64'(out_instr), 64'h0);
      if (m_cleared) begin
        chk("out_pc_clr", 64'(out_pc), 64'h0);
        chk("out_exc_clr", 64'(out_exc), 64'h0);
        chk("out_bd_clr", 64'(out_bd), 64'h0);
      end
    end
    chk("stall_cnt", 64'(stall_cnt), 64'(m_cnt));
  endtask

  // One clock: model evaluates the pre-edge handshake, then outputs are checked #1 after the edge.
  task automatic step();
    bit   ixf;
    bit   oxf;
    ent_t e;
    ixf = in_valid && (q.size() < 2);
    oxf = out_ready && (q.size() > 0);
    e.pc = in_pc; e.instr = in_instr; e.exc = in_exc; e.bd = in_bd;
    @(posedge clk);
    if (reset) begin
      q.delete();
      m_cnt = 0;
      m_cleared = 1'b1;
    end else begin
      if ((q.size() > 0) && !out_ready && (m_cnt < CNT_SAT)) m_cnt++;
      if (flush) begin
        q.delete();
        m_cleared = 1'b1;
      end else begin
        if (oxf) void'(q.pop_front());
        if (ixf) begin
          q.push_back(e);
          m_cleared = 1'b0;
        end
      end
    end
    #1;
    check_all();
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] instr,
                       input logic [4:0] exc, input logic bd);
    in_valid = v; in_pc = pc; in_instr = instr; in_exc = exc; in_bd = bd;
  endtask

  initial begin
    logic [31:0] pcs[3];
    logic [31:0] ins[3];
    pcs[0] = 32'h3000; pcs[1] = 32'h3004; pcs[2] = 32'h3008;
    ins[0] = 32'h24010001; ins[1] = 32'h24020002; ins[2] = 32'h00221821;

    // Reset then idle
    step(); step();
    reset = 1'b0;
    step(); step();
    chk("reset_stall", 64'(stall_cnt), 64'h0);

    // Streaming with out_ready held high
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, pcs[i], ins[i], 5'd0, 1'b0);
      step();
      chk("stream_pc", 64'(out_pc), 64'(pcs[i]));
    end
    drive(1'b0, '0, '0, '0, 1'b0);
    step(); step();

    // Back-pressure: stall after the first beat, keep pushing
    drive(1'b1, pcs[0], ins[0], 5'd0, 1'b0);
    step();
    out_ready = 1'b0;
    drive(1'b1, pcs[1], ins[1], 5'd0, 1'b1);
    step();
    chk("bp_in_ready_low", 64'(in_ready), 64'h0);
    drive(1'b1, pcs[2], ins[2], 5'd0, 1'b0);
    step(); step();
    chk("bp_hold_pc", 64'(out_pc), 64'h3000);
    out_ready = 1'b1;
    step();
    chk("bp_second_pc", 64'(out_pc), 64'h3004);
    step();
    chk("bp_third_pc", 64'(out_pc), 64'h3008);
    drive(1'b0, '0, '0, '0, 1'b0);
    step(); step();
    chk("bp_stall_total", 64'(stall_cnt), 64'd3);

    // Flush while FULL
    out_ready = 1'b0;
    drive(1'b1, pcs[0], ins[0], 5'd1, 1'b0);
    step();
    drive(1'b1, pcs[1], ins[1], 5'd2, 1'b1);
    step();
    drive(1'b0, '0, '0, '0, 1'b0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_valid", 64'(out_valid), 64'h0);
    chk("flush_pc", 64'(out_pc), 64'h0);
    chk("flush_in_ready", 64'(in_ready), 64'h1);
    chk("flush_stall_kept", 64'(stall_cnt), 64'd5);
    step();

    // Simultaneous in/out/flush while BUSY
    out_ready = 1'b1;
    drive(1'b1, 32'h3010, 32'h1, 5'd3, 1'b0);
    step();
    drive(1'b1, 32'h300C, 32'h2, 5'd4, 1'b1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    drive(1'b0, '0, '0, '0, 1'b0);
    chk("sim_flush_empty", 64'(out_valid), 64'h0);
    chk("sim_flush_exc", 64'(out_exc), 64'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("sim_flush_no300c", 64'(out_pc != 32'h300C), 64'h1);
    end

    // Saturation: 20 stalled cycles
    out_ready = 1'b0;
    drive(1'b1, 32'h4000, 32'h3, 5'd0, 1'b0);
    step();
    drive(1'b0, '0, '0, '0, 1'b0);
    for (int i = 0; i < 20; i++) step();
    chk("sat_stall", 64'(stall_cnt), 64'(CNT_SAT));
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("reset_clears_stall", 64'(stall_cnt), 64'h0);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      drive(1'($urandom_range(0, 3) != 0), $urandom(), $urandom(),
            5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
      out_ready = 1'($urandom_range(0, 2) != 0);
      flush = 1'($urandom_range(0, 15) == 0);
      reset = 1'($urandom_range(0, 99) == 0);
      step();
    end
    reset = 1'b0; flush = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
